hilo_mul_ctrl: RTL and testbench
================================

# hilo_mul_ctrl

Multi-cycle multiply sequencer and HI/LO register owner for the EXE stage of the 5-stage MIPS pipeline. It takes the multiply/HI/LO control flags and operands latched by the ID/EX pipeline register and runs a 32-step radix-2 shift-add unsigned multiply. It writes the 64-bit product to HI/LO and serves mthi/mtlo/mfhi/mflo. While a multiply is in flight, it raises `stall` to hold the ID/EX register and upstream stages whenever the EXE instruction touches HI/LO.

## Interface
- No parameters; datapath fixed at 32 bits, product 64 bits.
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- exe_valid  in  1  EXE stage holds a valid instruction
- exe_mult  in  1  EXE instruction is MULTU
- exe_mthi / exe_mtlo  in  1 each  EXE instruction writes HI / LO
- exe_mfhi / exe_mflo  in  1 each  EXE instruction reads HI / LO
- exe_operand1  in  32  multiplicand, or write data for mthi/mtlo
- exe_operand2  in  32  multiplier
- cancel  in  1  exception/eret flush of EXE; aborts any in-flight multiply
- busy  out  1  multiply in progress (state != IDLE)
- stall  out  1  hold ID/EX and upstream; EXE instruction must not advance
- hilo_rdata  out  32  mfhi ? HI : LO (combinational)
- hi, lo  out  32 each  architectural HI/LO contents

## Operation
- Flag priority, if more than one is set: mult > mthi > mtlo > mfhi > mflo. Lower-priority flags are ignored.
- `hit` = exe_valid & (exe_mult|exe_mthi|exe_mtlo|exe_mfhi|exe_mflo).
- `stall` = hit & busy & !cancel. Instructions that do not touch HI/LO never stall.
- `accept` = hit & !busy & !cancel.
- FSM states:
  - IDLE: on accept with exe_mult → MUL. Load mcand = {32'b0, operand1}, mplier = operand2, acc = 0, cnt = 0.
  - MUL: each edge, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt += 1. After the edge where cnt goes 31→32 (cnt is 6 bits, or 5 bits with a terminal flag) → WB.
  - WB: one edge; HI = acc[63:32], LO = acc[31:0]; → IDLE.
- cancel in MUL or WB → IDLE at next edge. HI/LO are not written and the aborted product is discarded.
- cancel together with an accepting mult in IDLE: cancel wins, no multiply starts.
- mthi/mtlo on accept: HI or LO = operand1 at that edge.
- mfhi/mflo: no state change. hilo_rdata is valid in any cycle with stall low.
- Arithmetic is unsigned, modulo 2^64; acc never overflows for 32×32 operands.
- Reset values: state IDLE, cnt 0, acc/mcand/mplier 0, HI = 0, LO = 0. Hence busy = 0, stall = 0, hilo_rdata = 0, hi = lo = 0.

## Timing
- Mult accepted at edge E0. busy is high from after E0 through E33; state is MUL for E1..E32 and WB at E33.
- HI/LO hold the new product after E33, and busy falls at the same edge.
- A mfhi/mflo waiting in EXE stalls in every cycle before E33. Its stall drops in the cycle after E33, where it reads the new value.
- A mthi/mtlo arriving during a multiply stalls the same way and writes after the multiply's WB. The younger write therefore wins.
- A second mult during busy stalls, then is accepted in the cycle after E33. There are no idle bubbles between back-to-back multiplies beyond the stall.
- Reset asserted mid-MUL: state returns to IDLE and HI/LO clear to 0 asynchronously, without waiting for a clock edge.
- Latency: 33 edges from accept to visible result. Throughput: one multiply per 34 cycles.

## Test plan
- Reset, then mult 3 × 5 → busy high for 33 edges, then HI = 0x00000000, LO = 0x0000000F, busy = 0.
- mult 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 after E33. Then mult 0x80000000 × 2 → HI = 0x00000001, LO = 0x00000000.
- Mult 7 × 9, then mflo presented at E0+1 → stall high through E33, low after; hilo_rdata = 0x0000003F. A non-HI/LO add in EXE during busy → stall = 0.
- mthi 0x12345678, mtlo 0x9ABCDEF0, mfhi → hilo_rdata = 0x12345678 with stall = 0. Mult 2 × 2 with cancel at E10 → HI/LO remain 0x12345678 / 0x9ABCDEF0, busy = 0 at E11.
- cancel and exe_mult in the same IDLE cycle → no state change. Reset asserted at E20 of a multiply → busy, HI, LO = 0 immediately. The next mult 4 × 4 gives LO = 0x10.

Source files
------------

// File: rtl/hilo_mul_ctrl.sv
// HI/LO register owner and 32-step radix-2 shift-add unsigned multiplier for the EXE stage.
// Holds the EXE instruction via stall while a multiply is in flight and the instruction touches HI/LO.
module hilo_mul_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_valid,
  input  logic        exe_mult,
  input  logic        exe_mthi,
  input  logic        exe_mtlo,
  input  logic        exe_mfhi,
  input  logic        exe_mflo,
  input  logic [31:0] exe_operand1,
  input  logic [31:0] exe_operand2,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_hi, r_lo;

  logic        w_hit, w_accept, w_start, w_wr_hi, w_wr_lo, w_commit, w_last;
  logic [63:0] w_addend;

  assign w_hit    = exe_valid & (exe_mult | exe_mthi | exe_mtlo | exe_mfhi | exe_mflo);
  assign busy     = (r_state != S_IDLE);
  assign stall    = w_hit & busy & ~cancel;
  assign w_accept = w_hit & ~busy & ~cancel;

  // Flag priority: mult > mthi > mtlo; reads need no decode beyond the mux.
  assign w_start  = w_accept & exe_mult;
  assign w_wr_hi  = w_accept & ~exe_mult & exe_mthi;
  assign w_wr_lo  = w_accept & ~exe_mult & ~exe_mthi & exe_mtlo;

  assign w_last   = (r_cnt == 6'd31);
  assign w_commit = (r_state == S_WB) & ~cancel;
  assign w_addend = r_mplier[0] ? r_mcand : 64'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_MUL;
      S_MUL: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_last) w_next = S_WB;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
    end else if (w_start) begin
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_mcand  <= {32'd0, exe_operand1};
      r_mplier <= exe_operand2;
    end else if (r_state == S_MUL) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
    end
  end

  // A commit and an mthi/mtlo accept are exclusive: accepts only happen when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= r_acc[63:32];
      r_lo <= r_acc[31:0];
    end else begin
      if (w_wr_hi) r_hi <= exe_operand1;
      if (w_wr_lo) r_lo <= exe_operand1;
    end
  end

  assign hi         = r_hi;
  assign lo         = r_lo;
  assign hilo_rdata = exe_mfhi ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Randomized and directed bench for hilo_mul_ctrl against a countdown/product reference model.
module tb_hilo_mul_ctrl;
  logic        clk, reset;
  logic        exe_valid, exe_mult, exe_mthi, exe_mtlo, exe_mfhi, exe_mflo, cancel;
  logic [31:0] exe_operand1, exe_operand2;
  logic        busy, stall;
  logic [31:0] hilo_rdata, hi, lo;

  hilo_mul_ctrl dut (
    .clk(clk), .reset(reset), .exe_valid(exe_valid), .exe_mult(exe_mult),
    .exe_mthi(exe_mthi), .exe_mtlo(exe_mtlo), .exe_mfhi(exe_mfhi), .exe_mflo(exe_mflo),
    .exe_operand1(exe_operand1), .exe_operand2(exe_operand2), .cancel(cancel),
    .busy(busy), .stall(stall), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges left until the pending product lands in HI/LO.
  int          rem;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_prod;
  logic        last_stall;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic m, input logic th, input logic tl,
                      input logic fh, input logic fl, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
    logic hit, mb;
    exe_valid = v; exe_mult = m; exe_mthi = th; exe_mtlo = tl;
    exe_mfhi = fh; exe_mflo = fl; exe_operand1 = a; exe_operand2 = b; cancel = c;
    @(negedge clk);
    hit = v & (m | th | tl | fh | fl);
    mb  = (rem > 0);
    chk("busy",  {63'd0, busy},  {63'd0, mb});
    chk("stall", {63'd0, stall}, {63'd0, hit & mb & ~c});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    chk("rdata", {32'd0, hilo_rdata}, {32'd0, fh ? m_hi : m_lo});
    last_stall = stall;
    last_rdata = hilo_rdata;
    @(posedge clk);
    if (mb && c) rem = 0;
    else if (mb) begin
      rem--;
      if (rem == 0) begin m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; end
    end else if (hit && !c) begin
      if (m) begin rem = 33; m_prod = {32'd0, a} * {32'd0, b}; end
      else if (th) m_hi = a;
      else if (tl) m_lo = a;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
  endtask

  task automatic mult(input logic [31:0] a, input logic [31:0] b);
    step(1, 1, 0, 0, 0, 0, a, b, 0);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  initial begin
    int stalls;
    logic [31:0] ra, rb;
    rem = 0; m_hi = 0; m_lo = 0; m_prod = 0;
    last_stall = 0; last_rdata = 0;
    reset = 1'b1;
    exe_valid = 0; exe_mult = 0; exe_mthi = 0; exe_mtlo = 0;
    exe_mfhi = 0; exe_mflo = 0; exe_operand1 = 0; exe_operand2 = 0; cancel = 0;
    #12;
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_rdata", {32'd0, hilo_rdata}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    mult(32'd3, 32'd5);
    idles(33);
    chk("m3x5_hi", {32'd0, hi}, 64'h0);
    chk("m3x5_lo", {32'd0, lo}, 64'hF);
    chk("m3x5_busy", {63'd0, busy}, 64'd0);

    mult(32'hFFFFFFFF, 32'hFFFFFFFF);
    idles(33);
    chk("mmax_hi", {32'd0, hi}, 64'hFFFFFFFE);
    chk("mmax_lo", {32'd0, lo}, 64'h1);
    mult(32'h80000000, 32'd2);
    idles(33);
    chk("mmsb_hi", {32'd0, hi}, 64'h1);
    chk("mmsb_lo", {32'd0, lo}, 64'h0);

    mult(32'd7, 32'd9);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 0, 0, 0, 1, 32'd0, 32'd0, 0);
      if (!last_stall) break;
      stalls++;
    end
    chk("mflo_stalls", stalls, 33);
    chk("mflo_rdata", {32'd0, last_rdata}, 64'h3F);

    mult(32'd11, 32'd13);
    step(1, 0, 0, 0, 0, 0, 32'd1, 32'd2, 0);
    chk("nonhilo_stall", {63'd0, last_stall}, 64'd0);
    idles(33);

    step(1, 0, 1, 0, 0, 0, 32'h12345678, 32'd0, 0);
    step(1, 0, 0, 1, 0, 0, 32'h9ABCDEF0, 32'd0, 0);
    step(1, 0, 0, 0, 1, 0, 32'd0, 32'd0, 0);
    chk("mfhi_rdata", {32'd0, last_rdata}, 64'h12345678);
    chk("mfhi_stall", {63'd0, last_stall}, 64'd0);

    mult(32'd2, 32'd2);
    idles(9);
    step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 1);
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    idles(30);
    chk("cancel_hi", {32'd0, hi}, 64'h12345678);
    chk("cancel_lo", {32'd0, lo}, 64'h9ABCDEF0);

    step(1, 1, 0, 0, 0, 0, 32'd3, 32'd3, 1);
    chk("cancel_idle_busy", {63'd0, busy}, 64'd0);
    idles(35);
    chk("cancel_idle_lo", {32'd0, lo}, 64'h9ABCDEF0);

    mult(32'd1234, 32'd5678);
    idles(19);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    rem = 0; m_hi = 0; m_lo = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    mult(32'd4, 32'd4);
    idles(33);
    chk("m4x4_lo", {32'd0, lo}, 64'h10);

    // Random traffic; operands occasionally forced to corner values.
    for (int i = 0; i < 4000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           ra, rb, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
